reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
// - Debug read-out engine for the CPU register file. On a start pulse it walks all register indices
//   through the register file's combinational read port and serialises them into a byte stream.
// - The stream uses a valid/ready handshake and feeds the UART TX path.
// - The frame is: sync byte, then per register an index byte plus 4 data bytes, MSB first.
// PARAMETERS
// - NUM_REGS    32     registers dumped, indices 0..NUM_REGS-1
// - ADDR_WIDTH  5      register index width, matches `REGS_WID
// - DATA_WIDTH  32     register width, matches `DATA_WID; must be a multiple of 8
// - SYNC_BYTE   8'hA5  first byte of every frame
// PORTS
// - clk       in   1           system clock, rising edge
// - rst       in   1           synchronous reset, active-high
// - start     in   1           1-cycle request to begin a dump; ignored while busy=1
// - rd_addr   out  ADDR_WIDTH  register file read index
// - rd_data   in   DATA_WIDTH  register file read data, combinational from rd_addr
// - tx_data   out  8           stream byte
// - tx_valid  out  1           byte valid
// - tx_ready  in   1           sink accepts the byte when tx_valid & tx_ready at posedge
// - busy      out  1           high from the cycle after start is accepted until the FIN cycle, inclusive
// - done      out  1           1-cycle pulse in FIN
// BEHAVIOUR
// - One clock (clk); rst is synchronous, active-high. All state updates on posedge clk.
// - Reset values: state=IDLE, idx=0, byte_cnt=0, word_q=0, rd_addr=0, tx_data=0, tx_valid=0,
//   busy=0, done=0. Reset mid-frame abandons the frame immediately; no partial-frame completion.
// - rd_addr is driven from the registered idx at all times.
// - FSM:
//   IDLE: start -> SYNC, idx<=0.
//   SYNC: tx_valid=1, tx_data=SYNC_BYTE. On handshake -> LOAD.
//   LOAD: tx_valid=0. word_q<=rd_data (snapshot for idx) -> IDX. Always exactly 1 cycle.
//   IDX:  tx_valid=1, tx_data={{(8-ADDR_WIDTH){1'b0}}, idx}. On handshake -> DATA, byte_cnt<=0.
//   DATA: tx_valid=1, tx_data=word_q[DATA_WIDTH-1 -: 8]. On handshake: word_q<<=8, byte_cnt++.
//         On the handshake of the last byte (byte_cnt==DATA_WIDTH/8-1):
//         idx==NUM_REGS-1 -> FIN; otherwise idx++ -> LOAD.
//   FIN:  done=1, tx_valid=0 -> IDLE.
// - Handshake rule: once tx_valid=1, tx_data is stable and tx_valid stays high until tx_ready is sampled high.
// - tx_ready is a don't-care while tx_valid=0.
// - Snapshot rule: register-file writes after LOAD do not alter the bytes of that register.
//   A write to a later register before its LOAD is reflected in the dump.
// - Frame length: 1 + NUM_REGS*(1+DATA_WIDTH/8) bytes (161 for the defaults).
// - Ready always high: start accepted at edge 0; done high in cycle 1+1+NUM_REGS*6 = 194.
// - start asserted in FIN or IDLE is accepted only in IDLE; start during any other state is dropped, not queued.
// - idx never wraps: the FIN exit occurs at NUM_REGS-1.
// STRUCTURE
// - Shared package/Const.svh gains: `DUMP_SYNC_BYTE, and typedef enum logic [2:0]
//   {DS_IDLE, DS_SYNC, DS_LOAD, DS_IDX, DS_DATA, DS_FIN} dump_state_t.
// - Single module. The byte shifter (word_q + byte_cnt) stays inline; no sub-module is warranted.
// TESTING
// - Preload regs x[i]=32'h1000_0000+i, tx_ready=1, pulse start
//   -> stream A5,00,10,00,00,00,01,10,00,00,01,...,1F,10,00,00,1F; 161 bytes; done at cycle 194, one cycle wide.
// - Random tx_ready (50%)
//   -> byte sequence identical to the previous test; tx_data and tx_valid never change while valid & !ready.
// - Write x5=32'hDEADBEEF one cycle after LOAD of idx 5 (old value 32'h1000_0005)
//   -> bytes for idx 5 are 05,10,00,00,05. Same write before LOAD of idx 5 -> 05,DE,AD,BE,EF.
// - Pulse start during DATA of idx 3
//   -> ignored; frame still 161 bytes; exactly one done pulse.
// - Assert rst while in DATA of idx 10, tx_ready=0
//   -> next cycle tx_valid=0, busy=0, rd_addr=0. A new start yields a full frame beginning with A5,00.
// - Hold start high continuously
//   -> back-to-back frames; second SYNC appears two cycles after done (FIN->IDLE->SYNC).

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and types for the register-file dump engine.
package reg_dump_reader_pkg;

  // First byte of every dump frame; lets the host find frame boundaries.
  localparam logic [7:0] DUMP_SYNC_BYTE = 8'hA5;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    DS_IDLE,
    DS_SYNC,
    DS_LOAD,
    DS_IDX,
    DS_DATA,
    DS_FIN
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks every register index through the
// combinational read port and serialises the frame
//   SYNC, { idx, data[MSB..LSB] } x NUM_REGS
// onto a valid/ready byte stream that feeds the UART TX path.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int         NUM_REGS   = 32,
  parameter int         ADDR_WIDTH = 5,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE  = DUMP_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic last_byte;
  logic last_reg;

  assign last_byte = (byte_cnt_q == BCW'(NBYTES - 1));
  assign last_reg  = (idx_q == ADDR_WIDTH'(NUM_REGS - 1));

  // The register file is addressed straight from the index counter.
  assign rd_addr = idx_q;

  // Sequencer next-state: snapshot in LOAD, shift the word out MSB first in DATA.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    case (state_q)
      DS_IDLE: begin
        if (start) begin
          state_d = DS_SYNC;
          idx_d   = '0;
        end
      end
      DS_SYNC: begin
        if (tx_ready) state_d = DS_LOAD;
      end
      DS_LOAD: begin
        // The word is frozen here so later writes cannot tear its bytes.
        word_d  = rd_data;
        state_d = DS_IDX;
      end
      DS_IDX: begin
        if (tx_ready) begin
          state_d    = DS_DATA;
          byte_cnt_d = '0;
        end
      end
      DS_DATA: begin
        if (tx_ready) begin
          word_d     = word_q << 8;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (last_byte) begin
            if (last_reg) begin
              state_d = DS_FIN;
            end else begin
              idx_d   = idx_q + ADDR_WIDTH'(1);
              state_d = DS_LOAD;
            end
          end
        end
      end
      DS_FIN: begin
        state_d = DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

  // Stream outputs are a pure function of the state, so data stays stable while stalled.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      DS_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
      end
      DS_IDX: begin
        tx_valid = 1'b1;
        tx_data  = 8'(idx_q);
      end
      DS_DATA: begin
        tx_valid = 1'b1;
        tx_data  = word_q[DATA_WIDTH-1 -: 8];
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
    busy = (state_q != DS_IDLE);
    done = (state_q == DS_FIN);
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DS_IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: stimulus pushes expected frame bytes into a
// queue, an independent monitor pops and compares on every handshake.
module tb_reg_dump_reader;

  localparam int NREG = 32;
  localparam int FRAME_LEN = 1 + NREG * 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  logic [31:0] regs [NREG];
  logic [7:0]  exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          nbytes  = 0;
  bit          rand_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  reg_dump_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: sync byte then index and big-endian word per register.
  task automatic push_frame(input logic [31:0] vals [NREG]);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back(8'(i));
      for (int b = 3; b >= 0; b--) exp_q.push_back(vals[i][8*b +: 8]);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000_0000 + i;
  endtask

  // Random back-pressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: byte order against the scoreboard and stability under stall.
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("hold_valid", {31'b0, tx_valid}, 32'd1);
      chk("hold_data", {24'b0, tx_data}, {24'b0, stall_data});
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      nbytes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_byte: got %0h, expected no byte", tx_data);
      end else begin
        chk($sformatf("byte%0d", nbytes - 1), {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      end
    end
    stall_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0) && !rst;
    stall_data = tx_data;
  end

  // mode 0: plain, 1: random ready, 2: start poke in DATA of idx 3,
  // 3: write x5 one cycle after its LOAD, 4: write x5 before its LOAD.
  task automatic run_frame(input int mode, input string tag);
    logic [31:0] vals [NREG];
    int  cyc;
    int  done_cyc;
    int  poke_st;
    int  extra_done;
    bit  armed;
    bit  wrote;
    preload();
    for (int i = 0; i < NREG; i++) vals[i] = regs[i];
    if (mode == 4) vals[5] = 32'hDEAD_BEEF;
    push_frame(vals);
    nbytes   = 0;
    done_cyc = -1;
    poke_st  = 0;
    armed    = 1'b0;
    wrote    = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    rand_ready = (mode == 1);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_c1"}, {31'b0, busy}, 32'd1);
      if (done === 1'b1) done_cyc = cyc;
      if (mode == 2) begin
        if (poke_st == 0 && rd_addr == 5'd3 && tx_valid && tx_data == 8'h03) poke_st = 1;
        else if (poke_st == 1) begin start = 1'b1; poke_st = 2; end
        else if (poke_st == 2) begin start = 1'b0; poke_st = 3; end
      end
      if (mode == 3 && !wrote) begin
        if (armed) begin regs[5] = 32'hDEAD_BEEF; wrote = 1'b1; end
        else if (rd_addr == 5'd5 && !tx_valid && busy) armed = 1'b1;
      end
      if (mode == 4 && !wrote && rd_addr == 5'd4 && !tx_valid && busy) begin
        regs[5] = 32'hDEAD_BEEF;
        wrote = 1'b1;
      end
    end
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    chk({tag, "_done_seen"}, {31'b0, (done_cyc > 0)}, 32'd1);
    if (mode == 1) chk({tag, "_done_min"}, {31'b0, (done_cyc >= 194)}, 32'd1);
    else           chk({tag, "_done_cyc"}, done_cyc, 32'd194);
    chk({tag, "_nbytes"}, nbytes, FRAME_LEN);
    chk({tag, "_queue_left"}, exp_q.size(), 32'd0);
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    chk({tag, "_done_width"}, extra_done, 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] vals [NREG];
    int cyc;
    int c1;
    bit seen;
    preload();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_addr", {27'b0, rd_addr}, 32'd0);
    chk("rst_data", {24'b0, tx_data}, 32'd0);

    run_frame(0, "basic");
    run_frame(1, "rready");
    run_frame(3, "wr_after");
    run_frame(4, "wr_before");
    run_frame(2, "poke");

    // Reset while stalled in DATA of idx 10.
    preload();
    for (int i = 0; i < NREG; i++) vals[i] = regs[i];
    push_frame(vals);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (rd_addr == 5'd10 && tx_valid && tx_data == 8'h0A) seen = 1'b1;
    end
    chk("rst_mid_reach", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1 tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_addr", {27'b0, rd_addr}, 32'd0);
    tx_ready = 1'b1;
    run_frame(0, "after_rst");

    // start held high: back-to-back frames.
    preload();
    for (int i = 0; i < NREG; i++) vals[i] = regs[i];
    push_frame(vals);
    push_frame(vals);
    nbytes = 0;
    @(posedge clk);
    #1 start = 1'b1;
    cyc = 0;
    c1 = -1;
    while (c1 < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) c1 = cyc;
    end
    chk("b2b_done1", {31'b0, (c1 > 0)}, 32'd1);
    @(negedge clk);
    chk("b2b_idle_valid", {31'b0, tx_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_sync_valid", {31'b0, tx_valid}, 32'd1);
    chk("b2b_sync_data", {24'b0, tx_data}, 32'hA5);
    start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("b2b_done2", {31'b0, seen}, 32'd1);
    chk("b2b_nbytes", nbytes, 2 * FRAME_LEN);
    chk("b2b_queue_left", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("b2b_final_idle", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
